// File: rtl/softmax_stream_ctrl_if.sv
// Stream and datapath signals of the softmax sequencer: serial element input, N-wide datapath link, serial result output.
// master = controller side, slave = host/datapath side.
interface softmax_stream_ctrl_if #(
    parameter int N = 64,
    parameter int W = 16
);
    logic             s_valid;
    logic [W-1:0]     s_data;
    logic             s_ready;
    logic             sm_en;
    logic             sm_valid_in;
    logic [N*W-1:0]   sm_in_x_flat;
    logic             sm_valid_out;
    logic [N*W-1:0]   sm_prob_flat;
    logic             m_valid;
    logic [W-1:0]     m_data;
    logic             m_ready;
    logic             m_last;

    modport master (
        input  s_valid, s_data, sm_valid_out, sm_prob_flat, m_ready,
        output s_ready, sm_en, sm_valid_in, sm_in_x_flat, m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, sm_valid_out, sm_prob_flat, m_ready,
        input  s_ready, sm_en, sm_valid_in, sm_in_x_flat, m_valid, m_data, m_last
    );
endinterface

// File: rtl/softmax_stream_ctrl.sv
// Gathers N serial Q8.8 elements, fires the softmax datapath, replays the N results serially; WAIT watchdog under `SOFTMAX_TIMEOUT_EN.
// Latency: N load + 1 fire + datapath + 1 capture + N drain cycles; s_ready low from FIRE to last drain beat, m_data/m_last hold while m_ready is low.
module softmax_stream_ctrl #(
    parameter int N       = 64,
    parameter int W       = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    softmax_stream_ctrl_if.master bus,
    output logic                 busy,
    output logic [15:0]          vec_count,
    output logic                 err_timeout
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_FIRE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("softmax_stream_ctrl: N must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("softmax_stream_ctrl: TIMEOUT must be >= 1");
    end

    logic [1:0]     state;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  didx;
    logic [IW-1:0]  didx_nx;
    logic [N*W-1:0] in_flat;
    logic [N*W-1:0] res_flat;
    logic           s_ready_q;
    logic           m_valid_q;
    logic           m_last_q;
    logic [W-1:0]   m_data_q;
    logic           s_hs;
    logic           m_hs;
    logic           timeout_hit;

    assign s_hs    = bus.s_valid && s_ready_q;
    assign m_hs    = m_valid_q && bus.m_ready;
    assign didx_nx = didx + 1'b1;

`ifdef SOFTMAX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          err_q;

    // A result arriving on the final count still wins over the abort.
    assign timeout_hit = (state == ST_WAIT) && !bus.sm_valid_out
                         && (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_FIRE)
                wait_cnt <= '0;
            else if (state == ST_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_LOAD;
            idx       <= '0;
            didx      <= '0;
            in_flat   <= '0;
            res_flat  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            vec_count <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    s_ready_q <= 1'b1;
                    if (s_hs) begin
                        in_flat[idx*W +: W] <= bus.s_data;
                        idx                 <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state     <= ST_FIRE;
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                ST_FIRE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.sm_valid_out) begin
                        res_flat  <= bus.sm_prob_flat;
                        m_valid_q <= 1'b1;
                        m_data_q  <= bus.sm_prob_flat[W-1:0];
                        m_last_q  <= 1'b0;
                        didx      <= '0;
                        state     <= ST_DRAIN;
                    end else if (timeout_hit) begin
                        idx       <= '0;
                        s_ready_q <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (m_hs) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            didx      <= '0;
                            idx       <= '0;
                            s_ready_q <= 1'b1;
                            vec_count <= vec_count + 16'd1;
                            state     <= ST_LOAD;
                        end else begin
                            didx     <= didx_nx;
                            m_data_q <= res_flat[didx_nx*W +: W];
                            m_last_q <= (didx_nx == LAST_IDX);
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.sm_en        = (state == ST_FIRE) || (state == ST_WAIT);
    assign bus.sm_valid_in  = (state == ST_FIRE);
    assign bus.sm_in_x_flat = in_flat;
    assign bus.m_valid      = m_valid_q;
    assign bus.m_data       = m_data_q;
    assign bus.m_last       = m_last_q;
    assign busy             = (state != ST_LOAD);
endmodule

// File: doc/softmax_stream_ctrl.md
Name: softmax_stream_ctrl

Overview:
Sequencer that sits between a serial Q8.8 element stream and the N-wide softmax datapath.
- Gathers N elements into the flat input vector.
- Fires the datapath with a single-cycle valid_in and holds en for the whole computation.
- Captures prob_flat on valid_out and replays the N probabilities serially on a valid/ready output stream.
- Replaces the free-running stimulus FSM when the datapath is driven from a host or DMA stream.

Parameters:
N, 64, elements per softmax vector.
W, 16, element width in bits (Q8.8).
TIMEOUT, 1024, max WAIT cycles before abort (used only with SOFTMAX_TIMEOUT_EN).

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset.
s_valid  input  1  input element valid.
s_data  input  W  input element, Q8.8 signed.
s_ready  output  1  controller accepts an element this cycle.
sm_en  output  1  softmax datapath enable.
sm_valid_in  output  1  softmax input-vector strobe.
sm_in_x_flat  output  N*W  packed vector; element i at bits [i*W +: W].
sm_valid_out  input  1  softmax result strobe.
sm_prob_flat  input  N*W  softmax result; element i at bits [i*W +: W].
m_valid  output  1  output probability valid.
m_data  output  W  output probability.
m_ready  input  1  downstream accepts.
m_last  output  1  high with m_valid on element N-1.
busy  output  1  high in FIRE, WAIT or DRAIN.
vec_count  output  16  completed vectors, wraps 0xFFFF -> 0.
err_timeout  output  1  sticky timeout flag.

Behaviour:
- Reset (rst==0 at an edge):
  - State = LOAD; load and drain indices = 0.
  - Outputs: s_ready=0 during reset, sm_en=0, sm_valid_in=0, m_valid=0, m_last=0, busy=0, vec_count=0, err_timeout=0.
  - sm_in_x_flat and the result buffer are cleared to 0.
  - Reset mid-operation discards any partial vector or undrained results. No handshake survives reset.
- LOAD:
  - s_ready=1, registered so it is high from the first cycle after reset release.
  - On s_valid&&s_ready, s_data is written to slot idx and idx increments.
  - Acceptance of slot N-1 -> FIRE next cycle, s_ready=0 from that cycle.
  - No s_valid: stay in LOAD, idx holds.
- FIRE (exactly 1 cycle): sm_valid_in=1, sm_en=1, sm_in_x_flat stable -> WAIT.
- WAIT:
  - sm_en=1, sm_valid_in=0, sm_in_x_flat held stable.
  - On sm_valid_out=1: latch sm_prob_flat into the result buffer -> DRAIN.
  - Latency of the datapath is unconstrained.
- sm_valid_out in any state other than WAIT is ignored. sm_en=0 outside FIRE and WAIT.
- DRAIN:
  - m_valid=1 and m_data=buf[didx], both registered.
  - m_data and m_last are held stable while m_valid && !m_ready.
  - On m_valid&&m_ready, didx advances.
  - The handshake with m_last=1 returns the state to LOAD with idx=0 and didx=0, and increments vec_count.
  - Loading does not overlap draining: s_ready=0 throughout DRAIN.
- Throughput with s_valid=m_ready=1: N load cycles + 1 FIRE + datapath latency + 1 capture + N drain cycles per vector.
- Widths: no arithmetic on data. Indices are clog2(N) bits; N must be a power of two >= 2.

Optional Feature:
SOFTMAX_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter is cleared on FIRE.
  - If the counter reaches TIMEOUT without sm_valid_out: err_timeout is set (sticky until reset), sm_en drops, the vector is discarded, state -> LOAD with idx=0, and vec_count is not incremented.
  - A sm_valid_out arriving in the same cycle as the TIMEOUT count wins: it is captured normally, with no error.
- Undefined: no counter exists; err_timeout is tied to 0 and WAIT waits indefinitely.

Test Plan:
- Reset then 64 elements 0x0100 with s_valid=1 -> s_ready falls after the 64th; one sm_valid_in pulse; sm_in_x_flat = all 0x0100.
- Model asserts sm_valid_out 5 cycles after FIRE with element i = i -> m_data sequence 0..63 with m_ready=1; m_last only on 63; vec_count=1; s_ready=1 the cycle after.
- m_ready toggled 1,0,0,1 during DRAIN -> m_data and m_last stable while stalled; no element dropped or duplicated.
- s_valid gaps (every 3rd cycle) -> slots filled in order; FIRE occurs only after 64 acceptances.
- rst=0 asserted after 30 elements, then a full vector -> no FIRE from the partial; the next vector is packed from slot 0.
- With SOFTMAX_TIMEOUT_EN and TIMEOUT=16, sm_valid_out never asserted -> err_timeout=1 on cycle 16 of WAIT; sm_en=0; LOAD resumes; vec_count unchanged.
